// File: rtl/ram_pkg.sv
// Shared types and helpers for the parametrised single-port RAM.
// Holds the clear-engine state encoding, read-during-write modes and lane merge.
package ram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam int RDW_WRITE_FIRST = 0;
    localparam int RDW_READ_FIRST  = 1;

    // One byte lane of a partial write: take the new byte only when enabled.
    function automatic logic [7:0] lane_merge(
        input logic [7:0] old_b,
        input logic [7:0] new_b,
        input logic       be_b
    );
        return be_b ? new_b : old_b;
    endfunction

endpackage

// File: rtl/ram_clear_fsm.sv
// Clear engine: walks every word address writing the fill value after reset or clr.
// Ports: clk, rst (sync, high), clr request; busy, clr_we strobe, clr_addr.
module ram_clear_fsm #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);
    import ram_pkg::*;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    // The counter wrapping past the last word ends the clear.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        unique case (state_q)
            ST_CLEAR: begin
                addr_d = addr_q + 1'b1;
                if (addr_q == '1) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                if (clr) begin
                    state_d = ST_CLEAR;
                    addr_d  = '0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                addr_d  = '0;
            end
        endcase
    end

    assign busy     = (state_q == ST_CLEAR);
    assign clr_we   = busy & ~rst;
    assign clr_addr = addr_q;

endmodule

// File: rtl/single_port_ram_param.sv
// Parametrised single-port RAM with byte enables, async or registered read
// and a built-in clear engine. Ports: clk, rst, clr, en, we, be, addr, din;
// outputs dout, dout_valid, busy.
module single_port_ram_param #(
    parameter int              DATA_W   = 16,
    parameter int              ADDR_W   = 4,
    parameter int              READ_REG = 0,
    parameter int              RDW_MODE = 0,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  en,
    input  logic                  we,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     din,
    output logic [DATA_W-1:0]     dout,
    output logic                  dout_valid,
    output logic                  busy
);
    import ram_pkg::*;

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int LANES = DATA_W / 8;

    generate
        if ((DATA_W % 8) != 0 || DATA_W == 0) begin : g_bad_width
            $error("DATA_W must be a non-zero multiple of 8");
        end
    endgenerate

    logic [DATA_W-1:0] mem [DEPTH];
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              acc;
    logic [DATA_W-1:0] old_word;
    logic [DATA_W-1:0] new_word;

    ram_clear_fsm #(
        .ADDR_W (ADDR_W)
    ) u_clear_fsm (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // clr wins over a same-edge access; that access is dropped.
    assign acc      = en & ~busy & ~clr & ~rst;
    assign old_word = mem[addr];

    always_comb begin
        new_word = old_word;
        for (int i = 0; i < LANES; i++) begin
            new_word[8*i +: 8] = lane_merge(old_word[8*i +: 8],
                                            din[8*i +: 8], be[i]);
        end
    end

    // clr_we only fires while busy and acc needs ~busy: never both.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= INIT_VAL;
        end else if (acc && we) begin
            mem[addr] <= new_word;
        end
    end

    generate
        if (READ_REG != 0) begin : g_reg_read
            logic [DATA_W-1:0] dout_q;
            logic              valid_q;
            logic [DATA_W-1:0] rd_word;

            assign rd_word = (we && RDW_MODE != RDW_READ_FIRST) ?
                             new_word : old_word;

            always_ff @(posedge clk) begin
                if (rst) begin
                    dout_q  <= '0;
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= acc;
                    if (acc) begin
                        dout_q <= rd_word;
                    end
                end
            end

            assign dout       = dout_q;
            assign dout_valid = valid_q;
        end else begin : g_async_read
            assign dout       = busy ? '0 : old_word;
            assign dout_valid = ~busy;
        end
    endgenerate

endmodule

// File: tb/tb_single_port_ram_param.sv
// Bench for single_port_ram_param: one async and two registered-read instances
// share stimulus; a model array and expected-value queues check every read.
module tb_single_port_ram_param;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        en  = 1'b0;
    logic        we  = 1'b0;
    logic [1:0]  be  = 2'b00;
    logic [3:0]  addr = 4'd0;
    logic [15:0] din = 16'h0000;

    logic [15:0] dout0, dout1, dout2;
    logic        valid0, valid1, valid2;
    logic        busy0, busy1, busy2;

    logic [15:0] m0 [16];
    logic [15:0] m1 [16];
    logic [15:0] q0 [$];
    logic [15:0] q1 [$];
    logic [15:0] q2 [$];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    single_port_ram_param #(
        .DATA_W(16), .ADDR_W(4), .READ_REG(0), .RDW_MODE(0),
        .INIT_VAL(16'h0000)
    ) dut0 (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .we(we), .be(be),
        .addr(addr), .din(din), .dout(dout0), .dout_valid(valid0),
        .busy(busy0)
    );

    single_port_ram_param #(
        .DATA_W(16), .ADDR_W(4), .READ_REG(1), .RDW_MODE(0),
        .INIT_VAL(16'hDEAD)
    ) dut1 (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .we(we), .be(be),
        .addr(addr), .din(din), .dout(dout1), .dout_valid(valid1),
        .busy(busy1)
    );

    single_port_ram_param #(
        .DATA_W(16), .ADDR_W(4), .READ_REG(1), .RDW_MODE(1),
        .INIT_VAL(16'hDEAD)
    ) dut2 (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .we(we), .be(be),
        .addr(addr), .din(din), .dout(dout2), .dout_valid(valid2),
        .busy(busy2)
    );

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mrg(input logic [15:0] o,
                                        input logic [15:0] n,
                                        input logic [1:0]  b);
        logic [15:0] r;
        r = o;
        if (b[0]) r[7:0]  = n[7:0];
        if (b[1]) r[15:8] = n[15:8];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_init();
        for (int i = 0; i < 16; i++) begin
            m0[i] = 16'h0000;
            m1[i] = 16'hDEAD;
        end
    endtask

    task automatic access(input logic w, input logic [3:0] a,
                          input logic [15:0] d, input logic [1:0] b);
        en = 1'b1; we = w; addr = a; din = d; be = b;
        #1;
        if (!w) begin
            q0.push_back(m0[a]);
            check("async_rd", dout0, q0.pop_front());
        end
        q1.push_back(w ? mrg(m1[a], d, b) : m1[a]);
        q2.push_back(m1[a]);
        if (w) begin
            m0[a] = mrg(m0[a], d, b);
            m1[a] = mrg(m1[a], d, b);
        end
        tick();
        en = 1'b0; we = 1'b0;
        check("reg_wf_dout", dout1, q1.pop_front());
        check("reg_rf_dout", dout2, q2.pop_front());
        check("reg_wf_valid", 16'(valid1), 16'd1);
        check("reg_rf_valid", 16'(valid2), 16'd1);
        if (w) begin
            #1;
            check("async_after_wr", dout0, m0[a]);
        end
    endtask

    task automatic read_all();
        for (int i = 0; i < 16; i++) begin
            access(1'b0, 4'(i), 16'h0000, 2'b00);
        end
    endtask

    task automatic fill();
        for (int i = 0; i < 16; i++) begin
            access(1'b1, 4'(i), 16'(i * 16'h0101 + 16'h0011), 2'b11);
        end
    endtask

    task automatic count_busy(input string tag, input int clr_at);
        int n = 0;
        while (busy0 && n < 100) begin
            clr = (n == clr_at);
            n++;
            tick();
            clr = 1'b0;
        end
        check(tag, 16'(n), 16'd16);
        check({tag, "_b1"}, 16'(busy1), 16'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        rst = 1'b1;
        tick();
        tick();
        check("rst_busy", 16'(busy0), 16'd1);
        check("rst_dout_async", dout0, 16'h0000);
        check("rst_dout_reg", dout1, 16'h0000);
        check("rst_valid_reg", 16'(valid1), 16'd0);
        check("rst_valid_async", 16'(valid0), 16'd0);
        rst = 1'b0;
        count_busy("rst_busy_len", -1);
        check("ready_valid_async", 16'(valid0), 16'd1);
        model_init();
        read_all();

        access(1'b1, 4'd3, 16'hA5A5, 2'b11);
        access(1'b1, 4'd3, 16'h5A5A, 2'b01);
        access(1'b1, 4'd3, 16'hFFFF, 2'b00);
        access(1'b0, 4'd3, 16'h0000, 2'b00);
        check("be_merge", dout1, 16'hA55A);
        access(1'b0, 4'd7, 16'h0000, 2'b00);
        check("be_untouched", dout2, 16'hDEAD);

        access(1'b1, 4'd7, 16'h1234, 2'b11);
        check("async_same_cycle", dout0, 16'h1234);
        addr = 4'd3;
        #1;
        check("async_addr_change", dout0, 16'hA55A);

        access(1'b1, 4'd5, 16'h1111, 2'b11);
        access(1'b1, 4'd5, 16'h2222, 2'b11);
        check("rdw_write_first", dout1, 16'h2222);
        check("rdw_read_first", dout2, 16'h1111);
        tick();
        check("idle_valid_wf", 16'(valid1), 16'd0);
        check("idle_valid_rf", 16'(valid2), 16'd0);
        check("idle_hold_wf", dout1, 16'h2222);
        check("idle_hold_rf", dout2, 16'h1111);

        fill();
        clr = 1'b1; en = 1'b1; we = 1'b1;
        addr = 4'd2; din = 16'hFFFF; be = 2'b11;
        tick();
        clr = 1'b0; en = 1'b0; we = 1'b0;
        check("clr_busy", 16'(busy0), 16'd1);
        check("clr_valid_reg", 16'(valid1), 16'd0);
        check("clr_dout_async", dout0, 16'h0000);
        check("clr_valid_async", 16'(valid0), 16'd0);
        count_busy("clr_busy_len", 3);
        model_init();
        read_all();

        fill();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (8) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        count_busy("rst_mid_busy_len", -1);
        model_init();
        read_all();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
